// File: rtl/imm_rotate_encoder_if.sv
// Start/done handshake and result bus for the immediate-operand encoder.
// The requester drives start/value; the encoder returns status and the encoded field.
interface imm_rotate_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic        inverted;
  logic [11:0] shift_operand;

  modport master (
    output start, value,
    input  busy, done, valid, inverted, shift_operand
  );

  modport slave (
    input  start, value,
    output busy, done, valid, inverted, shift_operand
  );
endinterface

// File: rtl/imm_rotate_encoder.sv
// Iterative search for {rotate_imm, eight_immed} reproducing a 32-bit constant,
// trying the value itself first and its complement second at each rotate.
module imm_rotate_encoder (
  input  logic                 clk,
  input  logic                 rst,
  imm_rotate_encoder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_rot;
  logic [31:0] r_v;
  logic        r_valid;
  logic        r_inv;
  logic [11:0] r_shop;

  logic [31:0] w_cand_dir;
  logic [31:0] w_cand_inv;
  logic        w_fit_dir;
  logic        w_fit_inv;

  // Rotate left by 2*r: upper half of the doubled word shifted left.
  function automatic logic [31:0] rol2r(input logic [31:0] x, input logic [3:0] r);
    logic [63:0] t;
    t = {x, x} << {r, 1'b0};
    return t[63:32];
  endfunction

  assign w_cand_dir = rol2r(r_v, r_rot);
  assign w_cand_inv = rol2r(~r_v, r_rot);
  assign w_fit_dir  = (w_cand_dir[31:8] == 24'd0);
  assign w_fit_inv  = (w_cand_inv[31:8] == 24'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rot   <= 4'd0;
      r_v     <= 32'd0;
      r_valid <= 1'b0;
      r_inv   <= 1'b0;
      r_shop  <= 12'h000;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_v     <= bus.value;
            r_rot   <= 4'd0;
            r_valid <= 1'b0;
            r_inv   <= 1'b0;
            r_state <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_fit_dir) begin
            r_shop  <= {r_rot, w_cand_dir[7:0]};
            r_valid <= 1'b1;
            r_inv   <= 1'b0;
            r_state <= DONE;
          end else if (w_fit_inv) begin
            r_shop  <= {r_rot, w_cand_inv[7:0]};
            r_valid <= 1'b1;
            r_inv   <= 1'b1;
            r_state <= DONE;
          end else if (r_rot == 4'd15) begin
            r_shop  <= 12'h000;
            r_valid <= 1'b0;
            r_inv   <= 1'b0;
            r_state <= DONE;
          end else begin
            r_rot <= r_rot + 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state == SEARCH);
  assign bus.done          = (r_state == DONE);
  assign bus.valid         = r_valid;
  assign bus.inverted      = r_inv;
  assign bus.shift_operand = r_shop;
endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Randomized and directed checks of imm_rotate_encoder against a brute-force
// decode-search model (every rotate, every byte, both polarities).
module tb_imm_rotate_encoder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  imm_rotate_encoder_if bus();

  imm_rotate_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  // Search the decode space directly: smallest rotate first, plain before complement.
  task automatic model(input logic [31:0] v, output logic ok, output logic inv,
                       output logic [11:0] so, output int lat);
    logic [31:0] target;
    logic [31:0] b32;
    logic        found;
    ok = 1'b0; inv = 1'b0; so = 12'h000; lat = 17; found = 1'b0;
    for (int r = 0; r < 16 && !found; r++) begin
      for (int form = 0; form < 2 && !found; form++) begin
        target = (form == 0) ? v : ~v;
        for (int b = 0; b < 256 && !found; b++) begin
          b32 = b;
          if (ror32(b32, 2 * r) == target) begin
            found = 1'b1;
            ok    = 1'b1;
            inv   = (form == 1);
            so    = {r[3:0], b32[7:0]};
            lat   = r + 2;
          end
        end
      end
    end
  endtask

  task automatic run_req(input logic [31:0] v, output int cyc, output logic bad_busy,
                         output logic o_ok, output logic o_inv, output logic [11:0] o_so);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = $urandom;
    cyc = 1;
    bad_busy = 1'b0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.inverted !== 1'b0) bad_busy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = -1;
    o_ok  = bus.valid;
    o_inv = bus.inverted;
    o_so  = bus.shift_operand;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.value = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.valid, bus.inverted, bus.shift_operand} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b inv=%b so=%h, want all 0",
               bus.busy, bus.done, bus.valid, bus.inverted, bus.shift_operand);
    end
    rst = 1'b0;
  endtask

  task automatic check_one(input string name, input logic [31:0] v);
    logic e_ok, e_inv, a_ok, a_inv, bad;
    logic [11:0] e_so, a_so;
    int e_lat, a_lat;
    model(v, e_ok, e_inv, e_so, e_lat);
    run_req(v, a_lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (a_lat != e_lat || a_ok !== e_ok || a_inv !== e_inv || a_so !== e_so || bad) begin
      n_fail++;
      $display("FAIL %s v=%h: got lat=%0d valid=%b inv=%b so=%h busybad=%b, want lat=%0d valid=%b inv=%b so=%h",
               name, v, a_lat, a_ok, a_inv, a_so, bad, e_lat, e_ok, e_inv, e_so);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_at_done: got %b want 0", name, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.shift_operand !== e_so || bus.valid !== e_ok) begin
      n_fail++;
      $display("FAIL %s_after_done: got done=%b so=%h valid=%b, want done=0 so=%h valid=%b",
               name, bus.done, bus.shift_operand, bus.valid, e_so, e_ok);
    end
  endtask

  task automatic test_directed();
    logic [31:0] tbl [8];
    tbl = '{32'h0000_00FF, 32'hFF00_0000, 32'h8000_0001, 32'h0000_0104,
            32'hFFFF_FF00, 32'h0000_0101, 32'h0000_0000, 32'hFFFF_FFFF};
    foreach (tbl[i]) check_one("directed", tbl[i]);
  endtask

  task automatic test_spec_values();
    logic a_ok, a_inv, bad;
    logic [11:0] a_so;
    int lat;
    run_req(32'h0000_0104, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 17 || a_so !== 12'hF41 || a_ok !== 1'b1 || a_inv !== 1'b0) begin
      n_fail++;
      $display("FAIL const_104: got lat=%0d so=%h valid=%b inv=%b, want 17 F41 1 0", lat, a_so, a_ok, a_inv);
    end
    run_req(32'h8000_0001, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 3 || a_so !== 12'h106 || a_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL const_wrap: got lat=%0d so=%h valid=%b, want 3 106 1", lat, a_so, a_ok);
    end
    run_req(32'hFFFF_FFFF, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 2 || a_so !== 12'h000 || a_ok !== 1'b1 || a_inv !== 1'b1) begin
      n_fail++;
      $display("FAIL const_allones: got lat=%0d so=%h valid=%b inv=%b, want 2 000 1 1", lat, a_so, a_ok, a_inv);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] b;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      b = $urandom_range(0, 255);
      case (k)
        0: v = ror32(b, 2 * $urandom_range(0, 15));
        1: v = ~ror32(b, 2 * $urandom_range(0, 15));
        2: v = ror32(b, $urandom_range(0, 31));
        default: v = $urandom;
      endcase
      check_one("random", v);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h0000_0104;
    @(negedge clk);
    bus.value = 32'h0000_00FF;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (cyc == 4) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (cyc != 17 || bus.shift_operand !== 12'hF41 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_start_search: got lat=%0d so=%h valid=%b, want 17 F41 1",
               cyc, bus.shift_operand, bus.valid);
    end
  endtask

  task automatic test_done_ignore();
    logic a_ok, a_inv, bad;
    logic [11:0] a_so;
    int lat;
    run_req(32'h0000_00FF, lat, bad, a_ok, a_inv, a_so);
    bus.start = 1'b1;
    bus.value = 32'h0000_0104;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ignore_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.shift_operand !== 12'h0FF || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignore_hold: got busy=%b so=%h valid=%b, want 0 0FF 1",
               bus.busy, bus.shift_operand, bus.valid);
    end
  endtask

  task automatic test_reset_mid();
    logic a_ok, a_inv, bad, saw_done;
    logic [11:0] a_so;
    int lat;
    run_req(32'hFF00_0000, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 6 || a_so !== 12'h4FF) begin
      n_fail++;
      $display("FAIL pre_reset_ff000000: got lat=%0d so=%h, want 6 4FF", lat, a_so);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h0000_0101;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.valid, bus.inverted, bus.shift_operand} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b valid=%b inv=%b so=%h, want all 0",
               bus.busy, bus.done, bus.valid, bus.inverted, bus.shift_operand);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got activity after abort, want none");
    end
    run_req(32'h0000_00FF, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 2 || a_so !== 12'h0FF || a_ok !== 1'b1 || a_inv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got lat=%0d so=%h valid=%b inv=%b, want 2 0FF 1 0",
               lat, a_so, a_ok, a_inv);
    end
  endtask

  task automatic test_back_to_back();
    logic a_ok, a_inv, bad;
    logic [11:0] a_so;
    int lat;
    run_req(32'hFFFF_FF00, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 2 || a_so !== 12'h0FF || a_inv !== 1'b1 || a_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d so=%h valid=%b inv=%b, want 2 0FF 1 1", lat, a_so, a_ok, a_inv);
    end
    run_req(32'h0000_0101, lat, bad, a_ok, a_inv, a_so);
    n_checks++;
    if (lat != 17 || a_so !== 12'h000 || a_ok !== 1'b0 || a_inv !== 1'b0 || bad) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d so=%h valid=%b inv=%b busybad=%b, want 17 000 0 0 0",
               lat, a_so, a_ok, a_inv, bad);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.value = 32'd0;
    test_reset();
    test_directed();
    test_spec_values();
    test_ignore_start();
    test_done_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_rotate_encoder.md
# imm_rotate_encoder

Iterative encoder for the data-processing immediate operand: given a 32-bit constant, finds the 12-bit shift_operand field {rotate_imm, eight_immed} whose decode, eight_immed rotated right by 2*rotate_imm, reproduces the constant. It also tries the bitwise complement so the caller can select an MVN/BIC-style form. It is the encoding counterpart of the Val2 immediate path. It sits beside the instruction-build and self-test logic and uses a start/done handshake.

## Interface
- No parameters. Widths are fixed by the instruction format.
- clk  in  1  clock. One clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- value  in  32  constant to encode. Latched on an accepted start.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse when a result is ready.
- valid  out  1  result is an exact encoding. Held until the next accepted start.
- inverted  out  1  encoding is of ~value, not value. Held.
- shift_operand  out  12  {rotate_imm[3:0], eight_immed[7:0]}. Held.

## Operation
- Decode rule: decoded value = ROR32(zero-extended eight_immed, 2*rotate_imm).
- Candidate for rotate r: c = ROL32(v, 2r). The candidate fits when c[31:8] == 0, giving eight_immed = c[7:0].
- Registers:
  - state: IDLE / SEARCH / DONE.
  - r: 4-bit rotate counter.
  - v: latched value.
  - result registers driving the outputs.
- IDLE:
  - busy=0, done=0.
  - On start=1: latch v=value, set r=0, clear valid and inverted, go to SEARCH.
- SEARCH, each cycle tests rotate r:
  - Direct hit: ROL32(v,2r) fits. Write shift_operand={r, ROL32(v,2r)[7:0]}, valid=1, inverted=0, go to DONE.
  - Inverted hit: the direct test misses and ROL32(~v,2r) fits. Write shift_operand={r, ROL32(~v,2r)[7:0]}, valid=1, inverted=1, go to DONE.
  - Priority: the direct form wins over the inverted form at the same r. The smallest r wins overall.
  - Miss with r==15: valid=0, inverted=0, shift_operand=12'h000, go to DONE.
  - Miss with r<15: r <= r+1 (no wrap past 15 is exercised).
- DONE: done=1 for exactly one cycle, then IDLE. A start asserted in DONE is ignored.
- start asserted in SEARCH is ignored. A change on value after latching has no effect.
- rst=1 mid-search: aborts the search. No done pulse is issued and all outputs return to their reset values.
- v=0: direct hit at r=0, shift_operand=12'h000, valid=1.
- v=0xFFFFFFFF: inverted hit at r=0, eight_immed=0x00, inverted=1.

## Timing
- Reset values: state=IDLE, r=0, busy=0, done=0, valid=0, inverted=0, shift_operand=12'h000.
- Let T be the cycle in which start=1 is sampled in IDLE.
  - Rotate r is tested in cycle T+1+r, with busy=1.
  - done=1 in cycle T+2+r, where r is the hit rotate.
  - Minimum latency is 2 cycles (hit at r=0). A full miss pulses done in cycle T+17.
- valid, inverted and shift_operand are registered and become valid in the same cycle as done. They are stable until the cycle after the next accepted start, when valid and inverted clear.
- The earliest next accepted start is the cycle after done (IDLE). Back-to-back throughput is one request per (latency+1) cycles.

## Test plan
- value=0x000000FF, start pulse -> done at T+2; valid=1, inverted=0, shift_operand=12'h0FF.
- value=0xFF000000 -> done at T+6; shift_operand=12'h4FF (r=4).
- value=0x80000001 (wraps the MSB/LSB boundary) -> done at T+3; shift_operand=12'h106.
- value=0x00000104 -> r=15, shift_operand=12'hF41, done at T+17.
- value=0xFFFFFF00 -> done at T+2; valid=1, inverted=1, shift_operand=12'h0FF.
- value=0x00000101 -> done at T+17; valid=0, inverted=0, shift_operand=12'h000.
- Busy/reset behaviour:
  - start re-asserted with value=0xFF during SEARCH -> ignored, the original result is returned.
  - rst=1 at T+5 of a long search -> no done pulse, all outputs return to reset values, next start is accepted normally.
